ham13_tx_arbiter: RTL and testbench
===================================

# ham13_tx_arbiter

Round-robin arbiter and sequencer that shares one `uart_tx_hamming13` transmitter among `NUM_REQ` byte producers. It sits directly in front of the encoder/transmitter and drives its `data_in`/`tx_start` pins. It holds the transmitter until `tx_done`, then optionally enforces an idle gap before the next frame. Each granted byte produces exactly one 2-UART-byte Hamming(13,8) frame on the serial line.

## Interface
- `NUM_REQ`, 4: number of requesters; 2..8.
- `GAP_CYCLES`, 1736: idle clocks inserted after each `tx_done`; 1736 is 4 bit times at 50 MHz/115200; 16-bit range.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `req_valid` in `NUM_REQ`: bit i set means requester i holds a byte to send.
- `req_data` in `NUM_REQ*8`: byte of requester i on `[i*8 +: 8]`.
- `req_ready` out `NUM_REQ`: one-hot, 1-cycle pulse; byte i accepted.
- `tx_data` out 8: byte to `uart_tx_hamming13.data_in`.
- `tx_start` out 1: 1-cycle start pulse to the transmitter.
- `tx_done` in 1: transmitter completion pulse, asserted after both UART bytes are sent.
- `busy` out 1: high from grant until return to IDLE.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last granted requester.
- `sent_pulse` out 1: 1-cycle pulse when the granted frame completes.
- `sent_id` out `$clog2(NUM_REQ)`: index of the completed frame, valid with `sent_pulse`.

## Operation
- States:
  - IDLE: waits for any `req_valid`.
  - START: drives the start pulse for one cycle.
  - WAIT_DONE: waits for `tx_done`.
  - GAP: counts the idle gap; present only with the macro.
- IDLE → START: at least one `req_valid` bit set.
  - Winner is the first set bit searching upward from `(last_grant+1) mod NUM_REQ`, with wrap-around.
  - Winner's byte latches into `tx_data` and its index into `grant_id` and `last_grant`.
- START → WAIT_DONE unconditionally. `tx_start=1` and `req_ready[grant_id]=1` during START only.
- WAIT_DONE → GAP, or → IDLE without the macro, when `tx_done` is sampled high. `sent_pulse=1` and `sent_id=grant_id` on the next cycle.
- GAP: counter loads `GAP_CYCLES`, decrements each clock, and moves to IDLE at 0. With `GAP_CYCLES=0`, go straight to IDLE.
- Requester protocol: `req_valid` and its data are held stable until `req_ready`. The arbiter samples requests only in IDLE. Requests arriving in other states wait without loss.
- `tx_done` is ignored in IDLE, START and GAP.
- `tx_data` holds its value after the frame; the transmitter latches its input at start.
- Reset values: state IDLE; `last_grant=NUM_REQ-1`, so requester 0 wins first after reset. All outputs are 0: `tx_start`, `tx_data`, `req_ready`, `busy`, `grant_id`, `sent_pulse`, `sent_id`.
- Reset mid-frame aborts immediately. The transmitter shares `rst_n`, so no partial frame completes and no `sent_pulse` is issued.

## Timing
- `req_valid` sampled in IDLE at edge k → `tx_start`, `req_ready` and `busy` high during cycle k+1. That is 1-cycle grant latency.
- `tx_done` sampled at edge d:
  - `sent_pulse` is high in cycle d+1.
  - With the macro: IDLE at d+1+`GAP_CYCLES`; the next `tx_start` comes no earlier than d+2+`GAP_CYCLES`.
  - Without the macro: IDLE at d+1; the next `tx_start` comes no earlier than d+2.
- `busy` drops on entry to IDLE.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- `HAM13_TX_GAP_EN` defined: GAP state and 16-bit gap counter are compiled in. Minimum inter-frame spacing is `GAP_CYCLES` clocks after `tx_done`.
- `HAM13_TX_GAP_EN` undefined: no counter or GAP state. `GAP_CYCLES` is ignored, and back-to-back frames are separated by the 2-cycle minimum only.

## Test plan
- **Single request:** hold `req_valid=4'b0100` with byte 0xA5 → one `req_ready=4'b0100` pulse, `tx_start` one cycle later with `tx_data=0xA5`, `grant_id=2`. After `tx_done`, `sent_pulse` with `sent_id=2`, and the decoded RX byte is 0xA5.
- **Round-robin fairness:** all 4 requesters valid continuously, with bytes 0x11/0x22/0x33/0x44 → grant order 0,1,2,3,0, and `sent_id` follows the same sequence.
- **Wrap-around:** last grant 3, then `req_valid=4'b0011` → requester 0 granted before 1.
- **Gap timing (macro on, `GAP_CYCLES=1736`):** `tx_done` at edge d → next `tx_start` exactly at cycle d+1738 with requests pending. With the macro off, the next `tx_start` is at d+2.
- **Stray `tx_done`:** pulse `tx_done` while in IDLE → no `sent_pulse`, no state change.
- **Reset mid-frame:** assert `rst_n=0` during WAIT_DONE → all outputs 0 immediately. After release, the first grant goes to the lowest valid index.

Source files
------------

// File: rtl/ham13_tx_arbiter.sv
// Round-robin arbiter that shares one Hamming(13,8) UART transmitter among NUM_REQ byte producers.
// Define HAM13_TX_GAP_EN to compile in the post-frame idle gap (GAP state + 16-bit counter).
module ham13_tx_arbiter #(
  parameter int  NUM_REQ    = 4,
  parameter int  GAP_CYCLES = 1736,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_start,
  input  logic                 tx_done,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic                 sent_pulse,
  output logic [ID_W-1:0]      sent_id
);

`ifdef HAM13_TX_GAP_EN
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE, S_GAP} state_e;
  localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES);
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_DONE} state_e;
`endif

  state_e               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [ID_W-1:0]      grant_id_q, grant_id_d;
  logic                 tx_start_q, tx_start_d;
  logic [NUM_REQ-1:0]   req_ready_q, req_ready_d;
  logic                 busy_q, busy_d;
  logic                 sent_pulse_q, sent_pulse_d;
  logic [ID_W-1:0]      sent_id_q, sent_id_d;
`ifdef HAM13_TX_GAP_EN
  logic [15:0]          gap_cnt_q, gap_cnt_d;
`endif

  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  int                   cand;

  // Rotating priority: scan upward from the requester after the last winner, wrapping once.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = int'(last_grant_q) + off;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    last_grant_d = last_grant_q;
    tx_data_d    = tx_data_q;
    grant_id_d   = grant_id_q;
    tx_start_d   = 1'b0;
    req_ready_d  = '0;
    busy_d       = busy_q;
    sent_pulse_d = 1'b0;
    sent_id_d    = sent_id_q;
`ifdef HAM13_TX_GAP_EN
    gap_cnt_d    = gap_cnt_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d              = S_START;
          last_grant_d         = win_idx;
          grant_id_d           = win_idx;
          tx_data_d            = req_data[{win_idx, 3'b000} +: 8];
          tx_start_d           = 1'b1;
          req_ready_d[win_idx] = 1'b1;
          busy_d               = 1'b1;
        end
      end

      S_START: state_d = S_WAIT_DONE;

      S_WAIT_DONE: begin
        if (tx_done) begin
          sent_pulse_d = 1'b1;
          sent_id_d    = grant_id_q;
`ifdef HAM13_TX_GAP_EN
          if (GAP_LOAD != 16'd0) begin
            state_d   = S_GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
`else
          state_d = S_IDLE;
          busy_d  = 1'b0;
`endif
        end
      end

`ifdef HAM13_TX_GAP_EN
      // The line stays quiet for GAP_LOAD clocks after tx_done before requests are looked at again.
      S_GAP: begin
        gap_cnt_d = gap_cnt_q - 16'd1;
        if (gap_cnt_d == 16'd0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
`endif

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      tx_data_q    <= '0;
      grant_id_q   <= '0;
      tx_start_q   <= 1'b0;
      req_ready_q  <= '0;
      busy_q       <= 1'b0;
      sent_pulse_q <= 1'b0;
      sent_id_q    <= '0;
`ifdef HAM13_TX_GAP_EN
      gap_cnt_q    <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      tx_data_q    <= tx_data_d;
      grant_id_q   <= grant_id_d;
      tx_start_q   <= tx_start_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      sent_pulse_q <= sent_pulse_d;
      sent_id_q    <= sent_id_d;
`ifdef HAM13_TX_GAP_EN
      gap_cnt_q    <= gap_cnt_d;
`endif
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_data    = tx_data_q;
  assign tx_start   = tx_start_q;
  assign busy       = busy_q;
  assign grant_id   = grant_id_q;
  assign sent_pulse = sent_pulse_q;
  assign sent_id    = sent_id_q;

endmodule

// File: tb/tb_ham13_tx_arbiter.sv
// Self-checking bench for ham13_tx_arbiter: timeline-based reference model plus directed scenarios.
// Works with HAM13_TX_GAP_EN defined or undefined.
module tb_ham13_tx_arbiter;
  localparam int NUM_REQ    = 4;
  localparam int GAP_CYCLES = 1736;
`ifdef HAM13_TX_GAP_EN
  localparam int G = GAP_CYCLES;
`else
  localparam int G = 0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic        tx_done = 1'b0;
  logic [3:0]  req_ready;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        busy;
  logic [1:0]  grant_id;
  logic        sent_pulse;
  logic [1:0]  sent_id;

  ham13_tx_arbiter #(.NUM_REQ(NUM_REQ), .GAP_CYCLES(GAP_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_start(tx_start), .tx_done(tx_done),
    .busy(busy), .grant_id(grant_id), .sent_pulse(sent_pulse), .sent_id(sent_id)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic [3:0]  smp_valid = '0;
  logic [31:0] smp_data = '0;
  logic        smp_done = 1'b0;
  int          edge_cnt = 0;

  always @(posedge clk) begin
    smp_valid <= req_valid;
    smp_data  <= req_data;
    smp_done  <= tx_done;
    edge_cnt  <= rst_n ? edge_cnt + 1 : 0;
  end

  // Reference model: tracks the frame timeline (grant edge, free-from edge) rather than states.
  int         cyc = 0;
  bit         m_in_frame = 0;
  int         m_gedge = 0;
  int         m_free = 0;
  int         m_last = NUM_REQ - 1;
  int         m_grant = 0;
  logic [7:0] m_tx_data = '0;
  bit         m_tx_start = 0;
  logic [3:0] m_ready = '0;
  bit         m_busy = 0;
  bit         m_sent = 0;
  int         m_sent_id = 0;

  task automatic model_reset();
    cyc = 0; m_in_frame = 0; m_gedge = 0; m_free = 0; m_last = NUM_REQ - 1;
    m_grant = 0; m_tx_data = '0; m_tx_start = 0; m_ready = '0; m_busy = 0;
    m_sent = 0; m_sent_id = 0;
  endtask

  task automatic model_step();
    int idx;
    cyc = edge_cnt;
    m_tx_start = 0; m_ready = '0; m_sent = 0;
    if (m_in_frame && cyc >= m_gedge + 2 && smp_done) begin
      m_in_frame = 0;
      m_sent     = 1;
      m_sent_id  = m_grant;
      m_free     = cyc + G;
    end else if (!m_in_frame && cyc > m_free && smp_valid != 4'b0) begin
      for (int off = 1; off <= NUM_REQ; off++) begin
        idx = (m_last + off) % NUM_REQ;
        if (!m_tx_start && smp_valid[idx]) begin
          m_tx_start   = 1;
          m_grant      = idx;
          m_last       = idx;
          m_tx_data    = smp_data[idx*8 +: 8];
          m_ready[idx] = 1'b1;
          m_in_frame   = 1;
          m_gedge      = cyc;
        end
      end
    end
    m_busy = m_in_frame || (cyc < m_free);
  endtask

  // Per-cycle compare against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        model_reset();
      end else if (edge_cnt != cyc) begin
        model_step();
      end
      check("cyc_tx_start",  tx_start,  m_tx_start);
      check("cyc_req_ready", req_ready, m_ready);
      check("cyc_busy",      busy,      m_busy);
      check("cyc_tx_data",   tx_data,   m_tx_data);
      check("cyc_grant_id",  grant_id,  (rst_n && cyc > 0) ? m_grant : 0);
      check("cyc_sent",      sent_pulse, m_sent);
      if (m_sent) check("cyc_sent_id", sent_id, m_sent_id);
    end
  end

  // Requester queues, transmitter responder and observation logs.
  logic [7:0] rbuf [4][16];
  int         rhead [4];
  int         rtail [4];
  int         tx_lat = 5;
  int         cd = 0;
  int         g_id[$];
  int         g_data[$];
  int         g_ready[$];
  int         g_edge[$];
  int         s_id[$];
  int         s_edge[$];

  task automatic drive_pins();
    for (int i = 0; i < 4; i++) begin
      req_valid[i]      = (rhead[i] != rtail[i]);
      req_data[i*8 +: 8] = req_valid[i] ? rbuf[i][rhead[i] % 16] : 8'h00;
    end
  endtask

  task automatic push(input int i, input logic [7:0] b);
    rbuf[i][rtail[i] % 16] = b;
    rtail[i]++;
    drive_pins();
  endtask

  task automatic tick();
    @(negedge clk);
    if (rst_n) begin
      for (int i = 0; i < 4; i++)
        if (req_ready[i] && rhead[i] != rtail[i]) rhead[i]++;
      if (tx_start) begin
        g_id.push_back(int'(grant_id));
        g_data.push_back(int'(tx_data));
        g_ready.push_back(int'(req_ready));
        g_edge.push_back(edge_cnt);
        cd = tx_lat;
      end
      if (sent_pulse) begin
        s_id.push_back(int'(sent_id));
        s_edge.push_back(edge_cnt);
      end
      tx_done = 1'b0;
      if (!tx_start && cd > 0) begin
        cd--;
        if (cd == 0) tx_done = 1'b1;
      end
    end
    drive_pins();
  endtask

  task automatic wait_sent(input string name, input int n, input int budget);
    int k = 0;
    while (s_id.size() < n && k < budget) begin tick(); k++; end
    check(name, s_id.size(), n);
  endtask

  task automatic wait_grant(input string name, input int n, input int budget);
    int k = 0;
    while (g_id.size() < n && k < budget) begin tick(); k++; end
    check(name, g_id.size(), n);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    check(name, busy, 1'b0);
  endtask

  int fair_id[6]  = '{0, 1, 2, 3, 0, 1};
  int fair_dat[6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h15, 8'h25};

  initial begin
    int gb, sb, p, ns, ng;
    for (int i = 0; i < 4; i++) begin rhead[i] = 0; rtail[i] = 0; end
    repeat (3) tick();
    check("reset_busy", busy, 1'b0);
    check("reset_tx_data", tx_data, 8'h00);
    rst_n = 1'b1;

    // Round-robin fairness from reset: every requester valid.
    push(0, 8'h11); push(0, 8'h15); push(1, 8'h22); push(1, 8'h25);
    push(2, 8'h33); push(3, 8'h44);
    wait_sent("fair_timeout", 6, 6 * (G + 40));
    for (int i = 0; i < 6; i++) begin
      check("fair_grant_id", g_id[i], fair_id[i]);
      check("fair_tx_data", g_data[i], fair_dat[i]);
      check("fair_sent_id", s_id[i], fair_id[i]);
    end
    wait_idle("fair_idle", G + 40);

    // Wrap-around: last grant 3, then requesters 0 and 1 together.
    push(3, 8'h5A);
    wait_sent("wrap3_timeout", 7, G + 40);
    check("wrap_first_is_3", g_id[6], 3);
    wait_idle("wrap_idle", G + 40);
    push(0, 8'h60); push(1, 8'h61);
    wait_sent("wrap_timeout", 9, 2 * (G + 40));
    check("wrap_grant_0", g_id[7], 0);
    check("wrap_grant_1", g_id[8], 1);
    check("wrap_data_1", g_data[8], 8'h61);
    wait_idle("wrap_idle2", G + 40);

    // Single request from requester 2 with 0xA5; one-cycle grant latency.
    tick();
    p = edge_cnt;
    push(2, 8'hA5);
    wait_sent("single_timeout", 10, G + 40);
    check("single_grant_id", g_id[9], 2);
    check("single_tx_data", g_data[9], 8'hA5);
    check("single_req_ready", g_ready[9], 4'b0100);
    check("single_latency", g_edge[9] - p, 1);
    check("single_sent_id", s_id[9], 2);
    wait_idle("single_idle", G + 40);

    // Gap timing: next request pending while the frame is in flight.
    gb = g_id.size(); sb = s_id.size();
    push(0, 8'h70);
    wait_grant("gap_grant_timeout", gb + 1, 20);
    push(1, 8'h71);
    wait_grant("gap_next_timeout", gb + 2, G + 60);
    check("gap_spacing", g_edge[gb + 1] - s_edge[sb], G + 1);
    check("gap_next_id", g_id[gb + 1], 1);
    wait_sent("gap_sent_timeout", sb + 2, G + 40);
    wait_idle("gap_idle", G + 40);

    // Stray tx_done in IDLE: nothing happens.
    repeat (3) tick();
    ns = s_id.size(); ng = g_id.size();
    tx_done = 1'b1;
    repeat (5) tick();
    check("stray_no_sent", s_id.size(), ns);
    check("stray_no_grant", g_id.size(), ng);
    check("stray_busy", busy, 1'b0);

    // Reset during WAIT_DONE aborts the frame.
    tx_lat = 30;
    gb = g_id.size();
    push(3, 8'h80);
    wait_grant("rst_grant_timeout", gb + 1, 20);
    repeat (3) tick();
    ns = s_id.size();
    #2 rst_n = 1'b0;
    #1;
    check("rst_tx_start", tx_start, 1'b0);
    check("rst_req_ready", req_ready, 4'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_grant_id", grant_id, 2'd0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_sent_pulse", sent_pulse, 1'b0);
    check("rst_sent_id", sent_id, 2'd0);
    cd = 0; tx_done = 1'b0;
    for (int i = 0; i < 4; i++) rhead[i] = rtail[i];
    push(1, 8'h81); push(2, 8'h82);
    repeat (3) tick();
    rst_n = 1'b1;
    tx_lat = 5;
    wait_sent("post_rst_timeout", ns + 2, 2 * (G + 40));
    check("post_rst_first", g_id[gb + 1], 1);
    check("post_rst_data", g_data[gb + 1], 8'h81);
    check("post_rst_second", g_id[gb + 2], 2);
    check("post_rst_sent0", s_id[ns], 1);
    check("post_rst_sent1", s_id[ns + 1], 2);
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
